// File: rtl/pkg_jogo.sv
// Shared definitions for the command evaluator: field widths, saturation limits,
// FSM state encodings and saturating arithmetic helpers.
package pkg_jogo;

    localparam int LARG_COMANDO   = 4;
    localparam int LARG_PONTUACAO = 16;
    localparam int LARG_CONTADOR  = 8;

    localparam logic [LARG_PONTUACAO-1:0] MAX_PONTUACAO = 16'hFFFF;
    localparam logic [LARG_CONTADOR-1:0]  MAX_CONTADOR  = 8'hFF;

    typedef logic [2:0] estado_t;

    localparam estado_t OCIOSO = 3'd0;
    localparam estado_t PEDIR  = 3'd1;
    localparam estado_t ESPERA = 3'd2;
    localparam estado_t JANELA = 3'd3;
    localparam estado_t AVALIA = 3'd4;
    localparam estado_t FIM    = 3'd5;

    // Score addition clamped at the top of the 16-bit range.
    function automatic logic [LARG_PONTUACAO-1:0] soma_saturada(
        input logic [LARG_PONTUACAO-1:0] valor,
        input logic [LARG_PONTUACAO:0]   incremento
    );
        logic [LARG_PONTUACAO:0] soma;
        soma = {1'b0, valor} + incremento;
        if (soma > {1'b0, MAX_PONTUACAO}) begin
            return MAX_PONTUACAO;
        end else begin
            return soma[LARG_PONTUACAO-1:0];
        end
    endfunction

    function automatic logic [LARG_CONTADOR-1:0] inc_saturado(
        input logic [LARG_CONTADOR-1:0] valor
    );
        if (valor == MAX_CONTADOR) begin
            return MAX_CONTADOR;
        end else begin
            return valor + 8'd1;
        end
    endfunction

endpackage

// File: rtl/sincronizador_de_botoes.sv
// Two-flop synchronizer for the four player buttons. With ANTIRREPIQUE_EN defined,
// each bit additionally needs ANTIRREPIQUE_CICLOS stable cycles before b_sync follows it.
module sincronizador_de_botoes
    import pkg_jogo::*;
#(
    parameter int ANTIRREPIQUE_CICLOS = 250000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LARG_COMANDO-1:0] botoes,
    output logic [LARG_COMANDO-1:0] b_sync
);

    logic [LARG_COMANDO-1:0] ff1_r;
    logic [LARG_COMANDO-1:0] ff2_r;

    // Metastability chain for the asynchronous buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff1_r <= 4'b0000;
            ff2_r <= 4'b0000;
        end else begin
            ff1_r <= botoes;
            ff2_r <= ff1_r;
        end
    end

`ifdef ANTIRREPIQUE_EN
    localparam int LARG_AR = $clog2(ANTIRREPIQUE_CICLOS + 1);
    localparam logic [LARG_AR-1:0] LIMITE_AR = LARG_AR'(ANTIRREPIQUE_CICLOS - 1);

    logic [LARG_AR-1:0]      cont_r [LARG_COMANDO];
    logic [LARG_COMANDO-1:0] estavel_r;

    // Per-button stability counter; the output only moves after a full run of the new level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estavel_r <= 4'b0000;
            for (int i = 0; i < LARG_COMANDO; i++) begin
                cont_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LARG_COMANDO; i++) begin
                if (ff2_r[i] == estavel_r[i]) begin
                    cont_r[i] <= '0;
                end else if (cont_r[i] == LIMITE_AR) begin
                    estavel_r[i] <= ff2_r[i];
                    cont_r[i]    <= '0;
                end else begin
                    cont_r[i] <= cont_r[i] + 1'b1;
                end
            end
        end
    end

    assign b_sync = estavel_r;
`else
    assign b_sync = ff2_r;
`endif

endmodule

// File: rtl/avaliador_de_comandos.sv
// Command evaluator: requests a command, collects button presses over a timed window
// and scores the result. Optional debounce is enabled with ANTIRREPIQUE_EN.
module avaliador_de_comandos
    import pkg_jogo::*;
#(
    parameter int JANELA_CICLOS       = 25000000,
    parameter int PONTOS_BASE         = 1,
    parameter int BONUS_COMBO         = 8,
    parameter int ANTIRREPIQUE_CICLOS = 250000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic [LARG_COMANDO-1:0]   botoes,
    input  logic [LARG_COMANDO-1:0]   prox_comando,
    input  logic                      fim_de_jogo,
    output logic                      trocar_comando,
    output logic                      acerto,
    output logic                      erro,
    output logic                      jogando,
    output logic [LARG_PONTUACAO-1:0] pontuacao,
    output logic [LARG_CONTADOR-1:0]  combo,
    output logic [LARG_CONTADOR-1:0]  erros
);

    localparam int LARG_JANELA = $clog2(JANELA_CICLOS);
    localparam logic [LARG_JANELA-1:0]  CARGA_JANELA = LARG_JANELA'(JANELA_CICLOS - 1);
    localparam logic [LARG_PONTUACAO:0] INC_BASE     = (LARG_PONTUACAO + 1)'(PONTOS_BASE);
    localparam logic [LARG_PONTUACAO:0] INC_BONUS    = (LARG_PONTUACAO + 1)'(2 * PONTOS_BASE);

    logic [LARG_COMANDO-1:0]   b_sync_s;

    estado_t                   estado_r,   estado_s;
    logic [LARG_COMANDO-1:0]   cmd_r,      cmd_s;
    logic [LARG_COMANDO-1:0]   mascara_r,  mascara_s;
    logic [LARG_JANELA-1:0]    janela_r,   janela_s;
    logic                      trocar_r,   trocar_s;
    logic                      acerto_r,   acerto_s;
    logic                      erro_r,     erro_s;
    logic                      jogando_r,  jogando_s;
    logic [LARG_PONTUACAO-1:0] pont_r,     pont_s;
    logic [LARG_CONTADOR-1:0]  combo_r,    combo_s;
    logic [LARG_CONTADOR-1:0]  erros_r,    erros_s;

    sincronizador_de_botoes #(
        .ANTIRREPIQUE_CICLOS (ANTIRREPIQUE_CICLOS)
    ) u_sincronizador (
        .clk    (clk),
        .reset  (reset),
        .botoes (botoes),
        .b_sync (b_sync_s)
    );

    // Next-state logic; the verdict is computed on the last window cycle so that
    // acerto/erro and the counters are already registered while in AVALIA.
    always_comb begin
        estado_s  = estado_r;
        cmd_s     = cmd_r;
        mascara_s = mascara_r;
        janela_s  = janela_r;
        acerto_s  = 1'b0;
        erro_s    = 1'b0;
        pont_s    = pont_r;
        combo_s   = combo_r;
        erros_s   = erros_r;

        case (estado_r)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    pont_s   = 16'd0;
                    combo_s  = 8'd0;
                    erros_s  = 8'd0;
                    estado_s = PEDIR;
                end else begin
                    estado_s = estado_r;
                end
            end
            PEDIR: begin
                estado_s = ESPERA;
            end
            ESPERA: begin
                if (fim_de_jogo) begin
                    estado_s = FIM;
                end else begin
                    cmd_s     = prox_comando;
                    mascara_s = 4'b0000;
                    janela_s  = CARGA_JANELA;
                    estado_s  = JANELA;
                end
            end
            JANELA: begin
                mascara_s = mascara_r | b_sync_s;
                if (janela_r == '0) begin
                    estado_s = AVALIA;
                    if (mascara_s == cmd_r) begin
                        acerto_s = 1'b1;
                        combo_s  = inc_saturado(combo_r);
                        if (int'(combo_r) >= BONUS_COMBO) begin
                            pont_s = soma_saturada(pont_r, INC_BONUS);
                        end else begin
                            pont_s = soma_saturada(pont_r, INC_BASE);
                        end
                    end else begin
                        erro_s  = 1'b1;
                        combo_s = 8'd0;
                        erros_s = inc_saturado(erros_r);
                    end
                end else begin
                    janela_s = janela_r - 1'b1;
                end
            end
            AVALIA: begin
                estado_s = PEDIR;
            end
            default: begin
                estado_s = OCIOSO;
            end
        endcase

        trocar_s  = (estado_s == PEDIR);
        jogando_s = (estado_s == PEDIR) || (estado_s == ESPERA) ||
                    (estado_s == JANELA) || (estado_s == AVALIA);
    end

    // State and registered outputs; reset discards any window in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_r  <= OCIOSO;
            cmd_r     <= 4'b0000;
            mascara_r <= 4'b0000;
            janela_r  <= '0;
            trocar_r  <= 1'b0;
            acerto_r  <= 1'b0;
            erro_r    <= 1'b0;
            jogando_r <= 1'b0;
            pont_r    <= 16'd0;
            combo_r   <= 8'd0;
            erros_r   <= 8'd0;
        end else begin
            estado_r  <= estado_s;
            cmd_r     <= cmd_s;
            mascara_r <= mascara_s;
            janela_r  <= janela_s;
            trocar_r  <= trocar_s;
            acerto_r  <= acerto_s;
            erro_r    <= erro_s;
            jogando_r <= jogando_s;
            pont_r    <= pont_s;
            combo_r   <= combo_s;
            erros_r   <= erros_s;
        end
    end

    assign trocar_comando = trocar_r;
    assign acerto         = acerto_r;
    assign erro           = erro_r;
    assign jogando        = jogando_r;
    assign pontuacao      = pont_r;
    assign combo          = combo_r;
    assign erros          = erros_r;

endmodule
